// File: rtl/tug_rope_referee.sv
// Purpose : tug-of-war referee; syncs two buttons, moves a one-hot rope marker, detects and holds wins.
// Latency : button sampled high at edge N moves score at edge N+2; win outputs change together on that edge.
// Backpres: none; a pull outside PLAY is dropped, and a held button produces only one pull.
//
// Ports:
//   clk, rst (sync, active-high)     - clock and reset
//   slowen                           - one-cycle tick pulse pacing SERVE and WIN holds
//   left_btn, right_btn              - asynchronous active-high player buttons
//   score[6:0]                       - LED bar: one-hot marker in play, win pattern after a win
//   wingame                          - win strobe, high across exactly one slowen tick
//   winner_right                     - last round won by the right player
//   rounds_left/right[3:0], match_over - round tallies and match decision
//
// Build option: define TUG_MATCH_EN to enable round counting and the DONE
// state. Without it the tallies and match_over stay 0 and play always re-serves.
module tug_rope_referee #(
    parameter int WIN_TICKS    = 13,
    parameter int SERVE_TICKS  = 2,
    parameter int MATCH_POINTS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slowen,
    input  logic       left_btn,
    input  logic       right_btn,
    output logic [6:0] score,
    output logic       wingame,
    output logic       winner_right,
    output logic [3:0] rounds_left,
    output logic [3:0] rounds_right,
    output logic       match_over
);

`ifdef TUG_MATCH_EN
    localparam bit MATCH_EN = 1'b1;
`else
    localparam bit MATCH_EN = 1'b0;
`endif

    localparam int CNT_MAX = (WIN_TICKS > SERVE_TICKS) ? WIN_TICKS : SERVE_TICKS;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_TICKS - 1);
    localparam logic [2:0]       POS_CENTRE = 3'd3;
    localparam logic [6:0]       PAT_RIGHT  = 7'b0000111;
    localparam logic [6:0]       PAT_LEFT   = 7'b1110000;

    typedef enum logic [2:0] {
        S_SERVE,
        S_PLAY,
        S_WIN_L,
        S_WIN_R,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       pos_q, pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wingame_q, wingame_d;
    logic             winner_right_q, winner_right_d;
    logic [3:0]       rounds_left_q, rounds_left_d;
    logic [3:0]       rounds_right_q, rounds_right_d;
    logic             match_over_q, match_over_d;

    // Two-flop synchronisers plus a previous-level flop for edge detection.
    logic left_s1_q, left_s1_d, left_s2_q, left_s2_d, left_prev_q, left_prev_d;
    logic right_s1_q, right_s1_d, right_s2_q, right_s2_d, right_prev_q, right_prev_d;

    logic       left_pull, right_pull;
    logic [3:0] rl_inc, rr_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_SERVE;
            pos_q          <= POS_CENTRE;
            cnt_q          <= '0;
            wingame_q      <= 1'b0;
            winner_right_q <= 1'b0;
            rounds_left_q  <= 4'd0;
            rounds_right_q <= 4'd0;
            match_over_q   <= 1'b0;
            left_s1_q      <= 1'b0;
            left_s2_q      <= 1'b0;
            left_prev_q    <= 1'b0;
            right_s1_q     <= 1'b0;
            right_s2_q     <= 1'b0;
            right_prev_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            cnt_q          <= cnt_d;
            wingame_q      <= wingame_d;
            winner_right_q <= winner_right_d;
            rounds_left_q  <= rounds_left_d;
            rounds_right_q <= rounds_right_d;
            match_over_q   <= match_over_d;
            left_s1_q      <= left_s1_d;
            left_s2_q      <= left_s2_d;
            left_prev_q    <= left_prev_d;
            right_s1_q     <= right_s1_d;
            right_s2_q     <= right_s2_d;
            right_prev_q   <= right_prev_d;
        end
    end

    // Edge flops track the synchronised level in every state, so a button
    // already held when PLAY begins does not count as a fresh pull.
    assign left_pull  = left_s2_q & ~left_prev_q;
    assign right_pull = right_s2_q & ~right_prev_q;

    // Saturating round increments.
    assign rl_inc = (rounds_left_q == 4'd15) ? 4'd15 : rounds_left_q + 4'd1;
    assign rr_inc = (rounds_right_q == 4'd15) ? 4'd15 : rounds_right_q + 4'd1;

    always_comb begin
        state_d        = state_q;
        pos_d          = pos_q;
        cnt_d          = cnt_q;
        wingame_d      = wingame_q;
        winner_right_d = winner_right_q;
        rounds_left_d  = rounds_left_q;
        rounds_right_d = rounds_right_q;
        match_over_d   = match_over_q;

        left_s1_d    = left_btn;
        left_s2_d    = left_s1_q;
        left_prev_d  = left_s2_q;
        right_s1_d   = right_btn;
        right_s2_d   = right_s1_q;
        right_prev_d = right_s2_q;

        case (state_q)
            S_SERVE: begin
                pos_d = POS_CENTRE;
                if (slowen) begin
                    if (cnt_q == SERVE_LAST) begin
                        state_d = S_PLAY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            // slowen is deliberately ignored here, so a tick coinciding with
            // the winning pull is not counted toward the win hold.
            S_PLAY: begin
                if (right_pull && !left_pull) begin
                    if (pos_q == 3'd1) begin
                        state_d        = S_WIN_R;
                        cnt_d          = '0;
                        wingame_d      = 1'b1;
                        winner_right_d = 1'b1;
                        if (MATCH_EN) begin
                            rounds_right_d = rr_inc;
                            if (rr_inc == 4'(MATCH_POINTS)) begin
                                match_over_d = 1'b1;
                            end
                        end
                    end else begin
                        pos_d = pos_q - 3'd1;
                    end
                end else if (left_pull && !right_pull) begin
                    if (pos_q == 3'd5) begin
                        state_d        = S_WIN_L;
                        cnt_d          = '0;
                        wingame_d      = 1'b1;
                        winner_right_d = 1'b0;
                        if (MATCH_EN) begin
                            rounds_left_d = rl_inc;
                            if (rl_inc == 4'(MATCH_POINTS)) begin
                                match_over_d = 1'b1;
                            end
                        end
                    end else begin
                        pos_d = pos_q + 3'd1;
                    end
                end
            end

            S_WIN_L, S_WIN_R: begin
                if (slowen) begin
                    wingame_d = 1'b0;
                    if (cnt_q == WIN_LAST) begin
                        cnt_d   = '0;
                        pos_d   = POS_CENTRE;
                        state_d = match_over_q ? S_DONE : S_SERVE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_DONE: begin
                wingame_d = 1'b0;
            end

            default: begin
                state_d = S_SERVE;
                pos_d   = POS_CENTRE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        score = 7'b0000000;
        case (state_q)
            S_SERVE, S_PLAY: score = 7'b0000001 << pos_q;
            S_WIN_R:         score = PAT_RIGHT;
            S_WIN_L:         score = PAT_LEFT;
            S_DONE:          score = winner_right_q ? PAT_RIGHT : PAT_LEFT;
            default:         score = 7'b0000000;
        endcase
    end

    assign wingame      = wingame_q;
    assign winner_right = winner_right_q;
    assign rounds_left  = rounds_left_q;
    assign rounds_right = rounds_right_q;
    assign match_over   = match_over_q;

endmodule

// File: tb/tb_tug_rope_referee.sv
// Purpose : directed self-checking bench for tug_rope_referee (default parameters).
// Latency : inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpres: n/a; all waits are fixed cycle counts.
module tb_tug_rope_referee;

`ifdef TUG_MATCH_EN
    localparam bit MATCH = 1'b1;
`else
    localparam bit MATCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       slowen = 1'b0;
    logic       left_btn = 1'b0;
    logic       right_btn = 1'b0;
    logic [6:0] score;
    logic       wingame;
    logic       winner_right;
    logic [3:0] rounds_left;
    logic [3:0] rounds_right;
    logic       match_over;

    int n_checks = 0;
    int n_pass   = 0;

    tug_rope_referee dut (
        .clk          (clk),
        .rst          (rst),
        .slowen       (slowen),
        .left_btn     (left_btn),
        .right_btn    (right_btn),
        .score        (score),
        .wingame      (wingame),
        .winner_right (winner_right),
        .rounds_left  (rounds_left),
        .rounds_right (rounds_right),
        .match_over   (match_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        slowen = 1'b1;
        step(1);
        slowen = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Press for three edges (enough for the move to land), then release and flush.
    task automatic press(input logic l, input logic r);
        left_btn  = l;
        right_btn = r;
        step(3);
        left_btn  = 1'b0;
        right_btn = 1'b0;
        step(3);
    endtask

    task automatic right_round();
        ticks(2);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
    endtask

    initial begin
        // Reset held for two cycles.
        step(2);
        rst = 1'b0;
        check("rst_score", 8'(score), 8'b0001000);
        check("rst_wingame", 8'(wingame), 8'd0);
        check("rst_winner", 8'(winner_right), 8'd0);
        check("rst_rounds_l", 8'(rounds_left), 8'd0);
        check("rst_rounds_r", 8'(rounds_right), 8'd0);
        check("rst_match", 8'(match_over), 8'd0);

        // Pulls in SERVE are ignored, before and after the first serve tick.
        press(1'b1, 1'b0);
        check("serve_left", 8'(score), 8'b0001000);
        press(1'b0, 1'b1);
        check("serve_right", 8'(score), 8'b0001000);
        tick();
        press(1'b1, 1'b0);
        check("serve_tick1_left", 8'(score), 8'b0001000);

        // Second tick enters PLAY; right presses walk toward bit 0.
        tick();
        press(1'b0, 1'b1);
        check("r_step1", 8'(score), 8'b0000100);
        press(1'b0, 1'b1);
        check("r_step2", 8'(score), 8'b0000010);

        // Winning press with latency check: nothing at N+1, everything at N+2.
        right_btn = 1'b1;
        step(2);
        check("r_win_early_score", 8'(score), 8'b0000010);
        check("r_win_early_wg", 8'(wingame), 8'd0);
        step(1);
        check("r_win_score", 8'(score), 8'b0000111);
        check("r_win_wg", 8'(wingame), 8'd1);
        check("r_win_winner", 8'(winner_right), 8'd1);
        check("r_win_rounds_r", 8'(rounds_right), MATCH ? 8'd1 : 8'd0);
        right_btn = 1'b0;
        step(3);

        // wingame is high during the first tick and drops after it.
        slowen = 1'b1;
        check("wg_during_tick", 8'(wingame), 8'd1);
        step(1);
        slowen = 1'b0;
        check("wg_after_tick", 8'(wingame), 8'd0);
        press(1'b1, 1'b0);
        check("win_ignores_pull", 8'(score), 8'b0000111);
        ticks(11);
        check("win_hold_12", 8'(score), 8'b0000111);
        tick();
        check("reserve_score", 8'(score), 8'b0001000);
        check("reserve_wg", 8'(wingame), 8'd0);

        // Back in PLAY: simultaneous pulls cancel, a held button steps once.
        ticks(2);
        press(1'b1, 1'b1);
        check("both_cancel", 8'(score), 8'b0001000);
        left_btn = 1'b1;
        step(50);
        check("held_left", 8'(score), 8'b0010000);
        left_btn = 1'b0;
        step(3);
        check("held_release", 8'(score), 8'b0010000);

        // A tick coinciding with a non-winning pull: pull still moves.
        left_btn = 1'b1;
        step(2);
        slowen = 1'b1;
        step(1);
        slowen = 1'b0;
        left_btn = 1'b0;
        step(3);
        check("pull_with_tick", 8'(score), 8'b0100000);

        // Left win with a coincident tick that must not count.
        left_btn = 1'b1;
        step(2);
        slowen = 1'b1;
        step(1);
        slowen = 1'b0;
        check("l_win_score", 8'(score), 8'b1110000);
        check("l_win_wg", 8'(wingame), 8'd1);
        check("l_win_winner", 8'(winner_right), 8'd0);
        check("l_win_rounds_l", 8'(rounds_left), MATCH ? 8'd1 : 8'd0);
        left_btn = 1'b0;
        step(3);
        tick();
        check("l_wg_after_tick", 8'(wingame), 8'd0);
        ticks(11);
        check("l_coincident_not_counted", 8'(score), 8'b1110000);

        // Reset mid-win.
        rst = 1'b1;
        step(1);
        check("midwin_rst_score", 8'(score), 8'b0001000);
        check("midwin_rst_wg", 8'(wingame), 8'd0);
        check("midwin_rst_rounds_l", 8'(rounds_left), 8'd0);
        check("midwin_rst_rounds_r", 8'(rounds_right), 8'd0);
        rst = 1'b0;
        step(1);

`ifdef TUG_MATCH_EN
        right_round();
        ticks(13);
        right_round();
        ticks(13);
        right_round();
        check("match_rounds_r", 8'(rounds_right), 8'd3);
        check("match_over", 8'(match_over), 8'd1);
        ticks(13);
        check("done_score", 8'(score), 8'b0000111);
        check("done_wg", 8'(wingame), 8'd0);
        press(1'b1, 1'b0);
        ticks(2);
        press(1'b1, 1'b0);
        check("done_ignores", 8'(score), 8'b0000111);
`else
        right_round();
        check("nomatch_rounds_r", 8'(rounds_right), 8'd0);
        check("nomatch_over", 8'(match_over), 8'd0);
        ticks(13);
        check("nomatch_reserve", 8'(score), 8'b0001000);
        ticks(2);
        press(1'b1, 1'b0);
        check("nomatch_replay", 8'(score), 8'b0010000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
